alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single-cycle combinational execute ALU between NUM_REQ requesters
//  (e.g. branch compare, address generation, integer ops). Round-robin grant,
//  valid/ready request and response handshakes, and a one-entry registered result buffer.
//  Sits between the requesters and the ALU; drives ALU op1/op2/alu_ops and samples alu_out.
// PARAMETERS
//  NUM_REQ  2  number of requesters (1..8); IDW = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1
// PORTS
//  clk          in   1           clock, all state updates on rising edge
//  rst_n        in   1           asynchronous reset, active-low
//  req_valid    in   NUM_REQ     per-requester request valid
//  req_ready    out  NUM_REQ     per-requester accept (one-hot or zero)
//  req_op1      in   32*NUM_REQ  operand 1, requester i at [32*i+:32]
//  req_op2      in   32*NUM_REQ  operand 2, requester i at [32*i+:32]
//  req_alu_ops  in   4*NUM_REQ   common:: ALU op code, requester i at [4*i+:4]
//  alu_op1      out  32          to ALU op1
//  alu_op2      out  32          to ALU op2
//  alu_ops      out  4           to ALU op select
//  alu_out      in   32          from ALU result (combinational)
//  resp_valid   out  1           result buffer holds a result
//  resp_ready   in   1           consumer takes the result this cycle
//  resp_id      out  IDW         index of requester that owns resp_data
//  resp_data    out  32          registered ALU result
// BEHAVIOUR
//  - Reset (async, rst_n=0): resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0;
//    a pending result is discarded, with no response for it after reset release.
//  - Buffer states: EMPTY (resp_valid=0), FULL (resp_valid=1).
//    accept_en = !resp_valid || resp_ready.
//  - Grant: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    Combinational. req_ready[g]=1 only if accept_en and a grant exists; else all 0.
//  - Requesters must not make req_valid depend on req_ready.
//    Operands stay stable while valid && !ready.
//  - alu_op1/op2/ops = granted requester's fields. They are 0 when there is no grant,
//    and also 0 when accept_en=0.
//  - Accept (handshake at edge): resp_data<=alu_out, resp_id<=g, resp_valid<=1,
//    rr_ptr<=(g+1) mod NUM_REQ. Latency: request accepted at edge N is visible
//    after edge N; throughput 1/cycle.
//  - Transitions: EMPTY->FULL on accept; FULL->EMPTY on resp_ready with no accept;
//    FULL->FULL on drain+accept in the same cycle, new result replaces old with
//    no bubble.
//  - FULL && !resp_ready: resp_data/resp_id held stable, all req_ready=0, rr_ptr frozen.
//  - No grant: rr_ptr unchanged. NUM_REQ=1: rr_ptr constant 0, resp_id constant 0.
//  - alu_ops passed through unfiltered; undefined codes yield whatever ALU returns (0).
// CONFIGURATION
//  ALU_ARB_PERF_EN defined: adds output perf_conflict_cnt [31:0].
//    - Counts cycles with >=2 req_valid bits set, plus cycles with any req_valid
//      while accept_en=0.
//    - Reset 0; saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1 Reset release, NUM_REQ=2, req0 ADD op1=5 op2=7, resp_ready=1
//    -> req_ready=2'b01 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=12.
//  2 Both valid every cycle, resp_ready=1: req0 SUB 10-3, req1 XOR F0^0F
//    -> grants alternate 0,1,0,1; responses 7 (id0), 0xFF (id1), in order, no gaps.
//  3 FULL with resp_ready=0 for 3 cycles, req1 valid
//    -> req_ready=0, resp_data/resp_id stable; on resp_ready=1 req1 accepted same
//       cycle, new result next cycle.
//  4 req0 SLT -1<1 (LT) accepted, rst_n asserted mid-cycle before consumption
//    -> resp_valid=0 immediately (async), resp_data=0, no response after release.
//  5 Only req1 valid, rr_ptr=0 -> grant 1, rr_ptr becomes 0; then req0,req1 both
//    valid -> req0 granted first.
//  6 ALU_ARB_PERF_EN: 4 cycles both valid, resp_ready=1 -> perf_conflict_cnt=4;
//    force-load near max -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter: round-robin sharing of one combinational ALU between
// NUM_REQ requesters with a one-entry result buffer. Option: ALU_ARB_PERF_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  input  logic [4*NUM_REQ-1:0]    req_alu_ops,
  output logic [31:0]             alu_op1,
  output logic [31:0]             alu_op2,
  output logic [3:0]              alu_ops,
  input  logic [31:0]             alu_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [31:0]             resp_data
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]             perf_conflict_cnt
`endif
);

  localparam logic [IDW-1:0] c_last_id = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_resp_id;
  logic [31:0]     r_resp_data;

  logic            w_accept_en;
  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_scan_id;
  logic            w_accept;

  logic [31:0]     w_op1 [NUM_REQ];
  logic [31:0]     w_op2 [NUM_REQ];
  logic [3:0]      w_ops [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_op1[i] = req_op1[32*i +: 32];
    assign w_op2[i] = req_op2[32*i +: 32];
    assign w_ops[i] = req_alu_ops[4*i +: 4];
  end

  assign resp_valid  = (r_state == ST_FULL);
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;
  assign w_accept_en = !resp_valid || resp_ready;

  // Scan starts at the round-robin pointer and wraps at the last requester.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_scan_id   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_found && req_valid[w_scan_id]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_scan_id;
      end
      w_scan_id = (w_scan_id == c_last_id) ? '0 : w_scan_id + IDW'(1);
    end
  end

  assign w_accept = w_accept_en && w_gnt_found;

  always_comb begin
    req_ready = '0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_ops   = '0;
    if (w_accept) begin
      req_ready[w_gnt_id] = 1'b1;
      alu_op1             = w_op1[w_gnt_id];
      alu_op2             = w_op2[w_gnt_id];
      alu_ops             = w_ops[w_gnt_id];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (!w_accept && resp_ready) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_data <= '0;
      r_resp_id   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_resp_data <= alu_out;
      r_resp_id   <= w_gnt_id;
      r_rr_ptr    <= (w_gnt_id == c_last_id) ? '0 : w_gnt_id + IDW'(1);
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_perf_cnt;
  logic        w_conflict;

  // Contention: several requesters at once, or any requester blocked by a full buffer.
  assign w_conflict = ($countones(req_valid) > 1) || ((|req_valid) && !w_accept_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (w_conflict && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_conflict_cnt = r_perf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter: vector table, hand sequences and randomized model
// comparison for alu_share_arbiter (NUM_REQ=2).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_arbiter;

  localparam int NREQ = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_op1;
  logic [32*NREQ-1:0] req_op2;
  logic [4*NREQ-1:0] req_alu_ops;
  logic [31:0]       alu_op1;
  logic [31:0]       alu_op2;
  logic [3:0]        alu_ops;
  logic [31:0]       alu_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [0:0]        resp_id;
  logic [31:0]       resp_data;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]       perf_conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_alu_ops (req_alu_ops),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_ops     (alu_ops),
    .alu_out     (alu_out),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'b0, $signed(a) < $signed(b)};
      4'd6: return {31'b0, a < b};
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_ops, alu_op1, alu_op2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
    req_valid   = v;
    req_alu_ops = {o1, o0};
    req_op1     = {a1, a0};
    req_op2     = {b1, b0};
    resp_ready  = rr;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  o0; logic [31:0] a0; logic [31:0] b0;
    logic [3:0]  o1; logic [31:0] a1; logic [31:0] b1;
    logic        rr;
    logic [1:0]  e_rdy;
    logic        e_vld;
    logic        e_id;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v,
                              input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic rr, input logic [1:0] e_rdy, input logic e_vld,
                              input logic e_id, input logic [31:0] e_data);
    vec_t r;
    r.v = v; r.o0 = o0; r.a0 = a0; r.b0 = b0; r.o1 = o1; r.a1 = a1; r.b1 = b1;
    r.rr = rr; r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_id = e_id; r.e_data = e_data;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    int    m_ptr;
    bit    m_full;
    logic [31:0] m_data;
    int    m_id;

    rst_n = 1'b0;
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
    #2;
    chk("reset_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_data", resp_data, 32'd0);
    chk("reset_id", {31'b0, resp_id}, 32'd0);
    chk("reset_ready", {30'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, alternating grants, then lone req1 and pointer wrap
    tbl.push_back(mk(2'b01, 4'd0, 32'd5,  32'd7,  4'd0, 32'd0,     32'd0,     1'b1, 2'b01, 1'b1, 1'b0, 32'd12));
    tbl.push_back(mk(2'b11, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFF));
    tbl.push_back(mk(2'b11, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b01, 1'b1, 1'b0, 32'd7));
    tbl.push_back(mk(2'b11, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFF));
    tbl.push_back(mk(2'b11, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b01, 1'b1, 1'b0, 32'd7));
    tbl.push_back(mk(2'b10, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFF));
    tbl.push_back(mk(2'b10, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFF));
    tbl.push_back(mk(2'b11, 4'd1, 32'd10, 32'd3,  4'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'b01, 1'b1, 1'b0, 32'd7));
    tbl.push_back(mk(2'b00, 4'd0, 32'd0,  32'd0,  4'd0, 32'd0,     32'd0,     1'b1, 2'b00, 1'b0, 1'b0, 32'd0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].o0, tbl[i].a0, tbl[i].b0, tbl[i].o1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      #1;
      chk($sformatf("tbl%0d_ready", i), {30'b0, req_ready}, {30'b0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'b0, resp_valid}, {31'b0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_id", i), {31'b0, resp_id}, {31'b0, tbl[i].e_id});
        chk($sformatf("tbl%0d_data", i), resp_data, tbl[i].e_data);
      end
    end

    // Backpressure: buffer full and not drained blocks all requesters
    @(negedge clk);
    drive(2'b01, 4'd0, 32'd1, 32'd2, 4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("bp_fill_data", resp_data, 32'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd100, 32'd23, 1'b0);
      #1;
      chk("bp_ready", {30'b0, req_ready}, 32'd0);
      chk("bp_aluop1", alu_op1, 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_data_hold", resp_data, 32'd3);
      chk("bp_id_hold", {31'b0, resp_id}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {30'b0, req_ready}, 32'd2);
    @(posedge clk); #1;
    chk("bp_new_data", resp_data, 32'd123);
    chk("bp_new_id", {31'b0, resp_id}, 32'd1);
    @(negedge clk);
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("bp_drained", {31'b0, resp_valid}, 32'd0);

    // Async reset while a result is pending
    @(negedge clk);
    drive(2'b01, 4'd5, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("slt_data", resp_data, 32'd1);
    @(negedge clk);
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("async_rst_data", resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    drive(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);
    #1;
    chk("post_rst_ptr0", {30'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_data", resp_data, 32'd2);

    // Randomized traffic against a transaction-level model
    do_reset();
    m_ptr = 0; m_full = 1'b0; m_data = 32'd0; m_id = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        en;
      int          g;
      logic [1:0]  e_rdy;
      logic [31:0] e_a, e_b;
      logic [3:0]  e_o;
      @(negedge clk);
      req_valid   = 2'($urandom);
      req_alu_ops = 8'($urandom);
      req_op1     = {$urandom, $urandom};
      req_op2     = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : {27'd0, 5'($urandom), 27'd0, 5'($urandom)};
      resp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      en = !m_full || resp_ready;
      g  = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
      e_rdy = '0; e_a = '0; e_b = '0; e_o = '0;
      if (en && g >= 0) begin
        e_rdy[g] = 1'b1;
        e_a = req_op1[32*g +: 32];
        e_b = req_op2[32*g +: 32];
        e_o = req_alu_ops[4*g +: 4];
      end
      chk("rnd_ready", {30'b0, req_ready}, {30'b0, e_rdy});
      chk("rnd_alu_op1", alu_op1, e_a);
      chk("rnd_alu_op2", alu_op2, e_b);
      chk("rnd_alu_ops", {28'b0, alu_ops}, {28'b0, e_o});
      @(posedge clk); #1;
      if (en && g >= 0) begin
        m_data = alu_fn(e_o, e_a, e_b);
        m_id   = g;
        m_full = 1'b1;
        m_ptr  = (g + 1) % NREQ;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
      chk("rnd_valid", {31'b0, resp_valid}, {31'b0, m_full});
      if (m_full) begin
        chk("rnd_data", resp_data, m_data);
        chk("rnd_id", {31'b0, resp_id}, 32'(m_id));
      end
    end

`ifdef ALU_ARB_PERF_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);
    end
    @(negedge clk);
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);
    #1;
    chk("perf_cnt4", perf_conflict_cnt, 32'd4);
    force dut.r_perf_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_perf_cnt;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);
    end
    @(negedge clk);
    drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);
    #1;
    chk("perf_saturate", perf_conflict_cnt, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
